// File: rtl/seq_addsub.sv
// seq_addsub
//   Multi-cycle adder/subtractor. Operands are latched on start, then summed
//   CHUNK bits per clock with the carry held in a register between chunks.
//   Result and flags are registered and only change when an operation ends.
//
// Parameters
//   WIDTH  operand/result width (>= 1)
//   CHUNK  bits summed per clock; WIDTH must be a multiple of CHUNK
//
// Ports
//   clk    clock, rising edge
//   rst    asynchronous reset, active-high
//   start  request, accepted only when not busy
//   SUB    0 = X+Y, 1 = X-Y (sampled with start)
//   X, Y   operands (sampled with start)
//   busy   operation in progress
//   done   one-cycle pulse when S and the flags are newly valid
//   S      result
//   COUT   carry out of the MSB (subtract: 1 = no borrow)
//   OVF    signed overflow
//   ZERO   S == 0
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             SUB,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg, acc_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             load, last;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state, load/last strobes and status outputs
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_reg == LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A new request here starts immediately, giving NCHUNK+1 throughput
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Select the current chunk and merge its sum into the accumulator
  always_comb begin
    a_chunk  = '0;
    b_chunk  = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_reg == CW'(i)) begin
        a_chunk = a_reg[i*CHUNK +: CHUNK];
        b_chunk = b_reg[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
    acc_next  = acc_reg;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_reg == CW'(i)) acc_next[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin
    msb_cin = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ acc_next[WIDTH-1];
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      S         <= '0;
      COUT      <= 1'b0;
      OVF       <= 1'b0;
      ZERO      <= 1'b0;
    end else if (load) begin
      // Subtract as X + ~Y + 1: invert B and seed the carry with SUB
      a_reg     <= X;
      b_reg     <= Y ^ {WIDTH{SUB}};
      carry_reg <= SUB;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      acc_reg   <= acc_next;
      carry_reg <= chunk_sum[CHUNK];
      cnt_reg   <= cnt_reg + 1'b1;
      if (last) begin
        S    <= acc_next;
        COUT <= chunk_sum[CHUNK];
        OVF  <= msb_cin ^ chunk_sum[CHUNK];
        ZERO <= (acc_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
module tb_seq_addsub;

  logic        clk;
  logic        rst;
  logic        start4, start16;
  logic        sub;
  logic [15:0] x, y;
  logic        busy4, done4, cout4, ovf4, zero4;
  logic        busy16, done16, cout16, ovf16, zero16;
  logic [15:0] s4, s16;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_s4 = 16'h0;
  logic [15:0] prev_s16 = 16'h0;

  seq_addsub #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .SUB(sub), .X(x), .Y(y),
    .busy(busy4), .done(done4), .S(s4), .COUT(cout4), .OVF(ovf4), .ZERO(zero4)
  );

  seq_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .SUB(sub), .X(x), .Y(y),
    .busy(busy16), .done(done16), .S(s16), .COUT(cout16), .OVF(ovf16), .ZERO(zero16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        sb;
    logic [15:0] xv, yv, es;
    logic        ec, eo, ez;
  } vec_t;

  vec_t vecs[7];

  // One operation on the selected instance, checked against hand-computed values
  task automatic op(input bit w, input string tag, input logic sb, input logic [15:0] xv,
                    input logic [15:0] yv, input logic [15:0] es, input logic ec,
                    input logic eo, input logic ez, input int elat);
    int lat;
    logic seen;
    @(negedge clk);
    sub = sb; x = xv; y = yv;
    if (w) start16 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start16 = 1'b0;
    if (!w) begin
      chk({tag, "_busy"}, 32'(busy4), 32'd1);
      chk({tag, "_hold"}, 32'(s4), 32'(prev_s4));
    end
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = w ? done16 : done4;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_S"},    32'(w ? s16 : s4),       32'(es));
    chk({tag, "_COUT"}, 32'(w ? cout16 : cout4), 32'(ec));
    chk({tag, "_OVF"},  32'(w ? ovf16 : ovf4),   32'(eo));
    chk({tag, "_ZERO"}, 32'(w ? zero16 : zero4), 32'(ez));
    chk({tag, "_nbusy"}, 32'(w ? busy16 : busy4), 32'd0);
    $display("op %s sub=%0d x=%h y=%h -> S=%h C=%0d V=%0d Z=%0d lat=%0d", tag, sb, xv, yv,
             w ? s16 : s4, w ? cout16 : cout4, w ? ovf16 : ovf4, w ? zero16 : zero4, lat);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(w ? done16 : done4), 32'd0);
    if (w) prev_s16 = es; else prev_s4 = es;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, first, second;
    vecs[0] = '{1'b0, 16'h0009, 16'h0007, 16'h0010, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h0007, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; start4 = 1'b0; start16 = 1'b0; sub = 1'b0; x = '0; y = '0;
    #12;
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_S", 32'(s4), 32'd0);
    chk("rst_flags", 32'({cout4, ovf4, zero4}), 32'd0);
    chk("rst16_all", 32'({busy16, done16, s16, cout16, ovf16, zero16}), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed add/subtract vectors
    for (int i = 0; i < 7; i++)
      op(1'b0, $sformatf("v%0d", i), vecs[i].sb, vecs[i].xv, vecs[i].yv,
         vecs[i].es, vecs[i].ec, vecs[i].eo, vecs[i].ez, 4);

    // start pulsed mid-RUN with other operands: must be ignored
    @(negedge clk);
    sub = 1'b0; x = 16'h0100; y = 16'h0020; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(negedge clk);
    sub = 1'b1; x = 16'hFFFF; y = 16'hFFFF; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    ndone = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done4) begin
        ndone++;
        if (first < 0) first = i;
      end
      if (done4) chk("ign_S", 32'(s4), 32'h0120);
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_when", 32'(first), 32'd2);
    $display("op ignore_start ndone=%0d first=%0d S=%h", ndone, first, s4);
    prev_s4 = 16'h0120;

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    sub = 1'b0; x = 16'hAAAA; y = 16'h1111; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy4), 32'd0);
    chk("arst_S", 32'(s4), 32'd0);
    chk("arst_flags", 32'({done4, cout4, ovf4, zero4}), 32'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    chk("arst_nodone", 32'(ndone), 32'd0);
    $display("op midrun_reset dones_after=%0d", ndone);
    prev_s4 = 16'h0;
    op(1'b0, "post_rst", 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 4);

    // Back-to-back, CHUNK=4: one done every 5 cycles
    @(negedge clk);
    sub = 1'b0; x = 16'h0001; y = 16'h0001; start4 = 1'b1;
    ndone = 0; first = -1; second = -1;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk); #1;
      if (done4) begin
        ndone++;
        if (first < 0) first = e; else if (second < 0) second = e;
      end
    end
    start4 = 1'b0;
    chk("b2b4_n", 32'(ndone), 32'd3);
    chk("b2b4_first", 32'(first), 32'd4);
    chk("b2b4_gap", 32'(second - first), 32'd5);
    chk("b2b4_S", 32'(s4), 32'h0002);
    $display("op b2b4 ndone=%0d first=%0d second=%0d", ndone, first, second);

    // CHUNK=16: single-edge latency
    op(1'b1, "c16", 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1);

    // Back-to-back, CHUNK=16: one done every 2 cycles
    @(negedge clk);
    sub = 1'b1; x = 16'h0005; y = 16'h0002; start16 = 1'b1;
    ndone = 0; first = -1; second = -1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (done16) begin
        ndone++;
        if (first < 0) first = e; else if (second < 0) second = e;
      end
    end
    start16 = 1'b0;
    chk("b2b16_n", 32'(ndone), 32'd5);
    chk("b2b16_first", 32'(first), 32'd1);
    chk("b2b16_gap", 32'(second - first), 32'd2);
    chk("b2b16_S", 32'(s16), 32'h0003);
    $display("op b2b16 ndone=%0d first=%0d second=%0d", ndone, first, second);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
